hamming_secded_pipe: RTL

//  Pipelined, parametrised SECDED (extended Hamming) decoder with valid/ready handshake and error statistics.

---
 rtl/hamming_secded_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage SECDED (extended Hamming) decoder with
// valid/ready flow control and saturating per-class error counters.
module hamming_secded_pipe #(
  parameter int N     = 11,
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int W    = N + R + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:W]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:N]       out_data,
  output logic             out_single,
  output logic             out_double,
  output logic [R-1:0]     out_syndrome,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  // codeword position of the k-th data bit (k = 1..N): k-th non-power-of-2 index
  function automatic int dpos(input int k);
    int c;
    c    = 0;
    dpos = 0;
    for (int i = 1; i <= N + R; i++)
      if ((i & (i - 1)) != 0) begin
        c++;
        if (c == k) dpos = i;
      end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:1]        vld_pipe;  // [1]: S1 holds a word, [2]: out_* hold a word
  logic              s1_load, s2_load, xfer;
  logic [R-1:0][1:W] sterm;
  logic [R-1:0]      syn_in;
  logic [1:N]        raw_data, fix_data;
  logic [1:N]        s1_data;
  logic [R-1:0]      s1_syn;
  logic              s1_par;
  logic              flip, sgl, dbl;

  // flow control: a stage advances when its successor can take the word
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_load   = !vld_pipe[1] || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_pipe[2];
  assign xfer      = vld_pipe[2] && out_ready;

  // syndrome bit b = parity of every Hamming position whose index has bit b set
  for (genvar b = 0; b < R; b++) begin : g_syn
    for (genvar i = 1; i <= W; i++) begin : g_term
      assign sterm[b][i] = (i <= N + R && ((i >> b) & 1) == 1) ? in_code[i] : 1'b0;
    end
    assign syn_in[b] = ^sterm[b];
  end

  // data extraction on input, and correction of a data bit named by the syndrome
  for (genvar k = 1; k <= N; k++) begin : g_data
    localparam int P = dpos(k);
    assign raw_data[k] = in_code[P];
    assign fix_data[k] = s1_data[k] ^ (flip && s1_syn == R'(P));
  end

  // classify the S1 word; only an in-range syndrome with odd parity is correctable
  always_comb begin
    sgl  = 1'b0;
    dbl  = 1'b0;
    flip = 1'b0;
    if (s1_syn == '0) begin
      sgl = s1_par;
    end else if (s1_par && int'(s1_syn) <= N + R) begin
      sgl  = 1'b1;
      flip = 1'b1;
    end else begin
      dbl = 1'b1;
    end
  end

  // stage occupancy; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      if (s2_load) vld_pipe[2] <= vld_pipe[1];
      if (s1_load) vld_pipe[1] <= in_valid;
    end
  end

  // S1: capture raw data bits, syndrome and overall parity
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data <= '0;
      s1_syn  <= '0;
      s1_par  <= 1'b0;
    end else if (s1_load && in_valid) begin
      s1_data <= raw_data;
      s1_syn  <= syn_in;
      s1_par  <= ^in_code;
    end
  end

  // S2: register classified/corrected result; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data     <= '0;
      out_single   <= 1'b0;
      out_double   <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load && vld_pipe[1]) begin
      out_data     <= fix_data;
      out_single   <= sgl;
      out_double   <= dbl;
      out_syndrome <= s1_syn;
    end
  end

  // statistics on delivered words; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_words  <= '0;
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (xfer) begin
      cnt_words <= sat_inc(cnt_words);
      if (out_single) cnt_single <= sat_inc(cnt_single);
      if (out_double) cnt_double <= sat_inc(cnt_double);
    end
  end

endmodule
